// File: rtl/serial_adder_pkg.sv
// Shared definitions for the arithmetic blocks: FSM state encoding and
// helpers used by the bit-serial adder.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Single-bit full-add sum, used as the functional definition of full_adder
    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Single-bit full-add carry
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full adder used by the bit-serial datapath.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured in IDLE, added LSB-first
// one bit per clock in SHIFT, and the result is held in DONE until the
// consumer takes it. All handshake outputs come straight from flops.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_s;
    logic             w_cout;

    // The only adder in the design: works on the current LSBs and carry flop
    full_adder u_full_adder (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Control FSM and datapath; handshake outputs are registered with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_sum       <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_sum       <= {WIDTH{1'b0}};
                        r_carry     <= 1'b0;
                        r_cnt       <= {CNT_W{1'b0}};
                        r_state     <= ST_SHIFT;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else begin
                        // Last result stays visible on sum/carry_out
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    // Sum fills from the MSB end so bit 0 lands last-in-first
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end else begin
                        r_state     <= ST_SHIFT;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    // No capture here: new operands wait for the IDLE cycle
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 8).
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    int n_checks;
    int n_errors;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case the design never reaches an expected state
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; the block is expected to be in IDLE
    task automatic accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input string tag);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    endtask

    // Wait for out_valid, checking latency, then the result
    task automatic wait_result(input int exp_lat, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_c, input string tag, output int busy_cnt);
        int lat;
        lat      = 0;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (out_valid !== 1'b1 && busy === 1'b1) busy_cnt++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " carry_out"}, 32'(carry_out), 32'(exp_c));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    logic [WIDTH-1:0] tab_a   [4];
    logic [WIDTH-1:0] tab_b   [4];
    logic [WIDTH-1:0] tab_s   [4];
    logic             tab_c   [4];

    initial begin
        int bc;
        int cyc;
        int last;
        int k;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        tab_a[0] = 8'h12; tab_b[0] = 8'h34; tab_s[0] = 8'h46; tab_c[0] = 1'b0;
        tab_a[1] = 8'hFF; tab_b[1] = 8'hFF; tab_s[1] = 8'hFE; tab_c[1] = 1'b1;
        tab_a[2] = 8'h00; tab_b[2] = 8'h00; tab_s[2] = 8'h00; tab_c[2] = 1'b0;
        tab_a[3] = 8'h7F; tab_b[3] = 8'h81; tab_s[3] = 8'h00; tab_c[3] = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst carry_out", 32'(carry_out), 32'd0);

        // First edge after reset release accepts: FF + 01
        rst = 1'b0;
        accept(8'hFF, 8'h01, "ff01");
        wait_result(WIDTH, 8'h00, 1'b1, "ff01", bc);
        handshake("ff01");
        check("ff01 sum retained in IDLE", 32'(sum), 32'h00);
        check("ff01 carry retained in IDLE", 32'(carry_out), 32'd1);

        // 5A + A5, busy exactly WIDTH cycles (accept sample plus shift samples)
        accept(8'h5A, 8'hA5, "5aa5");
        wait_result(WIDTH, 8'hFF, 1'b0, "5aa5", bc);
        check("5aa5 busy cycles", 32'(bc + 1), 32'(WIDTH));
        check("5aa5 busy low in DONE", 32'(busy), 32'd0);
        handshake("5aa5");

        // Backpressure: result held for 5 cycles
        accept(8'h3C, 8'h0F, "3c0f");
        wait_result(WIDTH, 8'h4B, 1'b0, "3c0f", bc);
        for (int i = 0; i < 5; i++) begin
            a        = 8'hEE;
            b        = 8'hEE;
            in_valid = 1'b1;
            step();
            check("bp sum", 32'(sum), 32'h4B);
            check("bp carry_out", 32'(carry_out), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake("3c0f");

        // in_valid pulsed during SHIFT is ignored
        accept(8'h01, 8'h02, "0102");
        step();
        step();
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result(WIDTH - 3, 8'h03, 1'b0, "0102", bc);
        handshake("0102");
        step();
        check("0102 no second capture busy", 32'(busy), 32'd0);
        check("0102 no second capture in_ready", 32'(in_ready), 32'd1);

        // Reset mid-SHIFT at counter = 4, asynchronously
        accept(8'h55, 8'h33, "abort");
        repeat (4) step();
        check("abort busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        accept(8'h80, 8'h80, "8080");
        wait_result(WIDTH, 8'h00, 1'b1, "8080", bc);
        handshake("8080");

        // Back-to-back with in_valid and out_ready held high
        k         = 0;
        a         = tab_a[0];
        b         = tab_b[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc       = 0;
        last      = -1;
        while (k < 4 && cyc < 200) begin
            step();
            cyc++;
            if (out_valid === 1'b1) begin
                check("b2b sum", 32'(sum), 32'(tab_s[k]));
                check("b2b carry_out", 32'(carry_out), 32'(tab_c[k]));
                if (last >= 0) check("b2b period", 32'(cyc - last), 32'(WIDTH + 2));
                last = cyc;
                k++;
                if (k < 4) begin
                    a = tab_a[k];
                    b = tab_b[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b results seen", 32'(k), 32'd4);
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        step();
        check("b2b idle at end", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operands a/b valid for capture.
REQ-005 SHALL have port in_ready  output  1  block idle and able to accept operands.
REQ-006 SHALL have port a  input  WIDTH  augend.
REQ-007 SHALL have port b  input  WIDTH  addend.
REQ-008 SHALL have port out_valid  output  1  sum/carry_out hold a completed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port sum  output  WIDTH  (a+b) mod 2^WIDTH.
REQ-011 SHALL have port carry_out  output  1  bit WIDTH of a+b.
REQ-012 SHALL have port busy  output  1  high while in SHIFT.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; state is registered.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015 On a clk edge in IDLE with in_valid=1: capture a and b into shift registers, clear the carry flop, clear the bit counter, clear the sum register, and go to SHIFT.
REQ-016 In SHIFT, each edge: add the LSBs of both shift registers and the carry flop using one-bit full-add logic; shift the result bit into the sum register MSB (LSB-first accumulation); update the carry flop; right-shift both operand registers; increment the counter.
REQ-017 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1, so SHIFT lasts exactly WIDTH cycles.
REQ-018 Latency: with acceptance on edge T, out_valid SHALL be high after edge T+WIDTH.
REQ-019 In DONE: out_valid=1; sum and carry_out SHALL hold stable until the handshake.
REQ-020 On an edge in DONE with out_ready=1: go to IDLE, and out_valid falls after that edge.
REQ-021 New operands SHALL NOT be accepted in the same cycle as result handshake; in_ready stays 0 in DONE.
REQ-022 in_valid in SHIFT or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-023 sum and carry_out SHALL retain the last result in IDLE until the next capture clears them.
REQ-024 Arithmetic: unsigned; the overflow beyond WIDTH bits appears only on carry_out, with no wrap flag.
REQ-025 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-026 rst=1 SHALL force, asynchronously: state=IDLE, sum=0, carry_out=0, carry flop=0, counter=0, out_valid=0, busy=0, in_ready=1.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; the partial result is discarded.
REQ-028 After rst deasserts, the first clk edge SHALL accept operands if in_valid=1.

Structure
REQ-029 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in a shared arithmetic-blocks package/include file.
REQ-030 The one-bit add SHALL be a combinational sub-module full_adder (a, b, cin -> s, cout), instantiated once.
REQ-031 The design SHALL have no combinational path from in_valid/out_ready to in_ready/out_valid.

Verification
REQ-032 a=8'hFF, b=8'h01, accepted on edge T -> out_valid high after edge T+8, sum=8'h00, carry_out=1.
REQ-033 a=8'h5A, b=8'hA5 -> sum=8'hFF, carry_out=0; busy high for exactly 8 cycles.
REQ-034 Backpressure: result 8'h3C+8'h0F held with out_ready=0 for 5 cycles -> sum=8'h4B and carry_out=0 remain stable, out_valid stays 1, and in_ready stays 0.
REQ-035 With in_valid pulsed (a=8'h11, b=8'h22) during SHIFT of 8'h01+8'h02 -> result is 8'h03 and the second operand pair is never captured.
REQ-036 rst asserted at SHIFT counter=4 -> immediately out_valid=0, sum=0, in_ready=1; then 8'h80+8'h80 -> sum=8'h00, carry_out=1.
REQ-037 Back-to-back: in_valid held high continuously -> one operation per WIDTH+2 cycles (SHIFT WIDTH cycles, DONE 1 cycle, IDLE 1 cycle), with all results correct against a reference model.
